// File: rtl/cp0_hazard_stall.sv
// Turns the CP0 EPC-hazard bubble code into a multi-cycle pipeline stall.
// PC and IF/ID are held and NOPs are injected into ID/EX until the pending
// mtc0-to-EPC write has committed. Also keeps a saturating count of injected NOPs.
module cp0_hazard_stall #(
    parameter int unsigned WB_DIST = 4,
    parameter int unsigned CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       cp0bubble,
    input  logic             ext_stall,
    input  logic             flush,
    output logic             pc_hold,
    output logic             ifid_hold,
    output logic             idex_bubble,
    output logic             busy,
    output logic [CNT_W-1:0] bubble_total
);

    localparam logic StIdle  = 1'b0;
    localparam logic StStall = 1'b1;

    localparam logic [3:0] WbDist = 4'(WB_DIST);

    logic             state_q, state_d;
    logic [2:0]       cnt_q, cnt_d;
    logic [CNT_W-1:0] total_q, total_d;

    logic [3:0] diff;
    logic [2:0] n_len;
    logic       n_pos;
    logic       stall_now;

    // Stall length from the code; a non-positive distance means no stall.
    always_comb begin
        diff  = WbDist - {2'b00, cp0bubble};
        n_len = diff[2:0];
        n_pos = ~diff[3] & (diff[2:0] != 3'd0);
    end

    // Mealy stall request: immediate in IDLE, forced in STALL, killed by flush or reset.
    always_comb begin
        stall_now = ~rst & ~flush &
                    ((state_q == StStall) |
                     ((state_q == StIdle) & (cp0bubble != 2'b00) & n_pos));
    end

    assign pc_hold      = stall_now;
    assign ifid_hold    = stall_now;
    assign idex_bubble  = stall_now;
    assign busy         = (state_q == StStall);
    assign bubble_total = total_q;

    // Next-state: flush beats ext_stall; the stall length is latched on entry only.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (flush) begin
            state_d = StIdle;
            cnt_d   = 3'd0;
        end else if (!ext_stall) begin
            if (state_q == StIdle) begin
                if ((cp0bubble != 2'b00) && n_pos && (n_len >= 3'd2)) begin
                    state_d = StStall;
                    cnt_d   = n_len - 3'd1;
                end
            end else begin
                if (cnt_q <= 3'd1) begin
                    state_d = StIdle;
                    cnt_d   = 3'd0;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
        end
    end

    // Count NOPs that actually advance into ID/EX, saturating at all-ones.
    always_comb begin
        total_d = total_q;
        if (stall_now && !ext_stall && (total_q != {CNT_W{1'b1}})) begin
            total_d = total_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    // State, remaining-cycle counter and statistics registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= 3'd0;
            total_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            total_q <= total_d;
        end
    end

endmodule

// File: tb/tb_cp0_hazard_stall.sv
// Directed bench for cp0_hazard_stall: inputs driven on negedge, outputs checked
// 1ns later, so combinational holds reflect the current cycle and registered
// outputs reflect the previous posedge.
module tb_cp0_hazard_stall;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  cp0bubble;
    logic        ext_stall;
    logic        flush;
    logic        pc_hold, ifid_hold, idex_bubble, busy;
    logic [31:0] bubble_total;
    logic        pc_hold4, ifid_hold4, idex_bubble4, busy4;
    logic [3:0]  bubble_total4;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    cp0_hazard_stall #(.WB_DIST(4), .CNT_W(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .cp0bubble    (cp0bubble),
        .ext_stall    (ext_stall),
        .flush        (flush),
        .pc_hold      (pc_hold),
        .ifid_hold    (ifid_hold),
        .idex_bubble  (idex_bubble),
        .busy         (busy),
        .bubble_total (bubble_total)
    );

    cp0_hazard_stall #(.WB_DIST(4), .CNT_W(4)) dut4 (
        .clk          (clk),
        .rst          (rst),
        .cp0bubble    (cp0bubble),
        .ext_stall    (ext_stall),
        .flush        (flush),
        .pc_hold      (pc_hold4),
        .ifid_hold    (ifid_hold4),
        .idex_bubble  (idex_bubble4),
        .busy         (busy4),
        .bubble_total (bubble_total4)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One cycle: drive at negedge, settle, leave checking to caller.
    task automatic cyc(input logic [1:0] code, input logic ext, input logic fl);
        @(negedge clk);
        cp0bubble = code;
        ext_stall = ext;
        flush     = fl;
        #1;
    endtask

    // Check the three holds (as one 3-bit vector), busy and total.
    task automatic chk(input string tag, input logic hold, input logic bsy, input int total);
        check_eq({tag, ".hold"}, {29'd0, pc_hold, ifid_hold, idex_bubble}, {29'd0, {3{hold}}});
        check_eq({tag, ".busy"}, {31'd0, busy}, {31'd0, bsy});
        check_eq({tag, ".total"}, bubble_total, total);
    endtask

    initial begin
        rst = 1'b1; cp0bubble = 2'd1; ext_stall = 1'b0; flush = 1'b0;
        #2;
        // Request during reset must be ignored.
        chk("rst", 1'b0, 1'b0, 0);
        check_eq("rst.total4", {28'd0, bubble_total4}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        cp0bubble = 2'd0;

        // code=1: three hold cycles, busy on 2-3, total 3.
        cyc(2'd1, 0, 0); chk("c1.a", 1, 0, 0);
        cyc(2'd0, 0, 0); chk("c1.b", 1, 1, 1);
        cyc(2'd0, 0, 0); chk("c1.c", 1, 1, 2);
        cyc(2'd0, 0, 0); chk("c1.d", 0, 0, 3);

        // code=3: single hold, no busy. code=2: two holds.
        cyc(2'd3, 0, 0); chk("c3.a", 1, 0, 3);
        cyc(2'd0, 0, 0); chk("c3.b", 0, 0, 4);
        cyc(2'd2, 0, 0); chk("c2.a", 1, 0, 4);
        cyc(2'd0, 0, 0); chk("c2.b", 1, 1, 5);
        cyc(2'd0, 0, 0); chk("c2.c", 0, 0, 6);

        // ext_stall for 4 cycles inside the stall: 7 hold cycles, +3 bubbles.
        cyc(2'd1, 0, 0); chk("ext.a", 1, 0, 6);
        for (int i = 0; i < 4; i++) begin
            cyc(2'd0, 1, 0); chk($sformatf("ext.f%0d", i), 1, 1, 7);
        end
        cyc(2'd0, 0, 0); chk("ext.b", 1, 1, 7);
        cyc(2'd0, 0, 0); chk("ext.c", 1, 1, 8);
        cyc(2'd0, 0, 0); chk("ext.d", 0, 0, 9);

        // flush in 2nd stall cycle: holds drop at once, IDLE next edge.
        cyc(2'd1, 0, 0); chk("fl.a", 1, 0, 9);
        cyc(2'd0, 0, 1); chk("fl.b", 0, 1, 10);
        cyc(2'd0, 0, 0); chk("fl.c", 0, 0, 10);

        // Stray code during STALL ignored; code=3 right after exit adds one hold.
        cyc(2'd1, 0, 0); chk("st.a", 1, 0, 10);
        cyc(2'd2, 0, 0); chk("st.b", 1, 1, 11);
        cyc(2'd0, 0, 0); chk("st.c", 1, 1, 12);
        cyc(2'd3, 0, 0); chk("st.d", 1, 0, 13);
        cyc(2'd0, 0, 0); chk("st.e", 0, 0, 14);

        // Saturation on the 4-bit counter instance.
        rst = 1'b1; #1;
        chk("rst2", 0, 0, 0);
        check_eq("rst2.total4", {28'd0, bubble_total4}, 32'd0);
        @(negedge clk); rst = 1'b0;
        for (int i = 0; i < 16; i++) cyc(2'd3, 0, 0);
        cyc(2'd0, 0, 0);
        check_eq("sat.total32", bubble_total, 32'd16);
        check_eq("sat.total4", {28'd0, bubble_total4}, 32'd15);
        cyc(2'd3, 0, 0);
        cyc(2'd0, 0, 0);
        check_eq("sat.hold4", {28'd0, bubble_total4}, 32'd15);

        // Async reset mid-stall.
        cyc(2'd1, 0, 0);
        cyc(2'd0, 0, 0); chk("mid.pre", 1, 1, 18);
        rst = 1'b1; #1;
        chk("mid.rst", 0, 0, 0);
        check_eq("mid.total4", {28'd0, bubble_total4}, 32'd0);
        check_eq("mid.hold4", {31'd0, pc_hold4}, 32'd0);
        @(negedge clk); rst = 1'b0;
        cyc(2'd0, 0, 0); chk("mid.post", 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
